// File: rtl/wb_burst_memtest_pkg.sv
// Shared types and constants for the Wishbone burst memory tester.
package wb_burst_memtest_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    WR_GAP   = 3'd2,
    RD_BURST = 3'd3,
    RD_GAP   = 3'd4,
    FINISH   = 3'd5
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  function automatic logic [15:0] burst_beats(input logic [15:0] remaining,
                                              input int unsigned max_beats);
    if (remaining < 16'(max_beats)) return remaining;
    return 16'(max_beats);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_burst_memtest_if.sv
// Wishbone B4 registered-feedback bus between the tester (master) and memory (slave).
interface wb_burst_memtest_if #(
  parameter int AW = 32
) ();
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_burst_memtest_pattern.sv
// Combinational test pattern: the low 32 bits of the byte address XORed with SEED.
module wb_memtest_pattern #(
  parameter int          AW   = 32,
  parameter logic [31:0] SEED = 32'hA5A5_5A5A
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   pattern_o
);
  logic [31:0] addr32;

  generate
    if (AW >= 32) begin : g_trunc
      assign addr32 = addr_i[31:0];
    end else begin : g_ext
      assign addr32 = {{(32 - AW){1'b0}}, addr_i};
    end
  endgenerate

  assign pattern_o = addr32 ^ SEED;
endmodule

// File: rtl/wb_burst_memtest.sv
// Writes an address-derived pattern over a region in incrementing Wishbone bursts,
// reads it back, and reports mismatches and ack timeouts.
module wb_burst_memtest
  import wb_burst_memtest_pkg::*;
#(
  parameter int          AW        = 32,
  parameter int          BURST_LEN = 4,
  parameter logic [31:0] SEED      = 32'hA5A5_5A5A,
  parameter int          TIMEOUT   = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   num_words,
  wb_burst_memtest_if.master wb,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] fail_addr
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  state_e         state_q;
  logic [AW-1:0]  adr_q;
  logic [AW-1:0]  base_q;
  logic [15:0]    num_q;
  logic [15:0]    words_q;
  logic [4:0]     beat_q;
  logic [WDW-1:0] wdog_q;
  logic [15:0]    err_q;
  logic [AW-1:0]  fail_q;
  logic           pass_q;
  logic           done_q;
  logic           cyc_q;
  logic           we_q;
  logic [2:0]     cti_q;
  logic [3:0]     sel_q;

  logic [31:0]    pattern;
  logic [AW-1:0]  adr_inc_d;
  logic [15:0]    err_inc_d;
  logic           mismatch_d;
  logic [15:0]    rem_sel_d;
  logic [4:0]     launch_beats_d;
  logic [2:0]     launch_cti_d;

  wb_memtest_pattern #(
    .AW   (AW),
    .SEED (SEED)
  ) u_pattern (
    .addr_i    (adr_q),
    .pattern_o (pattern)
  );

  assign adr_inc_d  = adr_q + AW'(4);
  assign err_inc_d  = sat_inc(err_q);
  assign mismatch_d = (wb.wb_dat_i != pattern);

  // Word count feeding the next burst: fresh start, read-pass restart, or remainder.
  always_comb begin
    rem_sel_d = words_q;
    if (state_q == IDLE) begin
      rem_sel_d = num_words;
    end else if (state_q == WR_GAP && words_q == 16'd0) begin
      rem_sel_d = num_q;
    end
  end

  assign launch_beats_d = 5'(burst_beats(rem_sel_d, BURST_LEN));
  assign launch_cti_d   = (launch_beats_d == 5'd1) ? CTI_EOB : CTI_INC;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      base_q  <= '0;
      num_q   <= '0;
      words_q <= '0;
      beat_q  <= '0;
      wdog_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      sel_q   <= 4'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            err_q  <= '0;
            fail_q <= '0;
            pass_q <= 1'b0;
            base_q <= base_addr;
            num_q  <= num_words;
            if (num_words == 16'd0) begin
              state_q <= FINISH;
            end else begin
              adr_q   <= base_addr;
              words_q <= num_words;
              beat_q  <= launch_beats_d;
              cti_q   <= launch_cti_d;
              wdog_q  <= '0;
              cyc_q   <= 1'b1;
              we_q    <= 1'b1;
              sel_q   <= 4'hF;
              state_q <= WR_BURST;
            end
          end
        end

        WR_BURST, RD_BURST: begin
          if (wb.wb_ack_i) begin
            adr_q   <= adr_inc_d;
            words_q <= words_q - 16'd1;
            beat_q  <= beat_q - 5'd1;
            wdog_q  <= '0;
            if (state_q == RD_BURST && mismatch_d) begin
              err_q <= err_inc_d;
              if (err_q == 16'd0) fail_q <= adr_q;
            end
            if (beat_q == 5'd1) begin
              cyc_q   <= 1'b0;
              cti_q   <= CTI_CLASSIC;
              state_q <= (state_q == WR_BURST) ? WR_GAP : RD_GAP;
            end else if (beat_q == 5'd2) begin
              cti_q <= CTI_EOB;
            end
          end else if (wdog_q == WDOG_LAST) begin
            // Slave never answered this beat: abandon the whole test.
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            err_q   <= err_inc_d;
            if (err_q == 16'd0) fail_q <= adr_q;
            state_q <= FINISH;
          end else begin
            wdog_q <= wdog_q + WDW'(1);
          end
        end

        WR_GAP: begin
          beat_q <= launch_beats_d;
          cti_q  <= launch_cti_d;
          wdog_q <= '0;
          cyc_q  <= 1'b1;
          if (words_q == 16'd0) begin
            adr_q   <= base_q;
            words_q <= num_q;
            we_q    <= 1'b0;
            state_q <= RD_BURST;
          end else begin
            state_q <= WR_BURST;
          end
        end

        RD_GAP: begin
          if (words_q == 16'd0) begin
            state_q <= FINISH;
          end else begin
            beat_q  <= launch_beats_d;
            cti_q   <= launch_cti_d;
            wdog_q  <= '0;
            cyc_q   <= 1'b1;
            state_q <= RD_BURST;
          end
        end

        FINISH: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == 16'd0);
          we_q    <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = we_q ? pattern : 32'd0;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_cti_o = cti_q;
  assign wb.wb_bte_o = BTE_LINEAR;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;

endmodule

// File: tb/tb_wb_burst_memtest.sv
// Directed bench: zero-wait memory model with optional read corruption and ack stall.
module tb_wb_burst_memtest;
  import wb_burst_memtest_pkg::*;

  localparam logic [31:0] SEED = 32'hA5A5_5A5A;
  localparam int BL = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] fail_addr;

  wb_burst_memtest_if #(.AW(32)) bus ();

  wb_burst_memtest #(
    .AW(32), .BURST_LEN(BL), .SEED(SEED), .TIMEOUT(255)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .wb(bus), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr)
  );

  always #5 wb_clk = ~wb_clk;

  // Memory model
  logic [31:0] mem [0:255];
  logic        corrupt_en = 1'b0, stall_en = 1'b0;
  logic [31:0] corrupt_addr = '0, stall_addr = '0;
  logic [7:0]  midx;
  assign midx = bus.wb_adr_o[9:2];

  always_comb begin
    bus.wb_ack_i = bus.wb_cyc_o && bus.wb_stb_o && !(stall_en && bus.wb_adr_o == stall_addr);
    bus.wb_dat_i = mem[midx] ^ ((corrupt_en && bus.wb_adr_o == corrupt_addr) ? 32'h0000_0100 : 32'h0);
  end

  always @(posedge wb_clk)
    if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_we_o && bus.wb_ack_i) mem[midx] <= bus.wb_dat_o;

  // Bus monitor: beat log, stall count, gap/protocol violations, done pulses
  int          nbeats, stall_cnt, proto_bad, done_cnt, gap_len;
  bit          had_burst, after_eob;
  logic [31:0] b_adr [0:63];
  logic [31:0] b_dat [0:63];
  logic [2:0]  b_cti [0:63];
  logic        b_we  [0:63];

  always @(negedge wb_clk) begin
    if (start && !busy) begin
      nbeats = 0; stall_cnt = 0; proto_bad = 0; done_cnt = 0; gap_len = 0;
      had_burst = 0; after_eob = 0;
    end else begin
      if (done) done_cnt++;
      if (bus.wb_cyc_o !== bus.wb_stb_o) proto_bad++;
      if (bus.wb_cyc_o) begin
        if (after_eob) proto_bad++;
        if (had_burst && gap_len > 1) proto_bad++;
        if (bus.wb_sel_o !== 4'hF || bus.wb_bte_o !== 2'b00) proto_bad++;
        gap_len = 0; had_burst = 1; after_eob = 0;
        if (bus.wb_ack_i) begin
          if (nbeats < 64) begin
            b_adr[nbeats] = bus.wb_adr_o; b_dat[nbeats] = bus.wb_dat_o;
            b_cti[nbeats] = bus.wb_cti_o; b_we[nbeats] = bus.wb_we_o;
          end
          nbeats++;
          if (bus.wb_cti_o == CTI_EOB) after_eob = 1;
        end else begin
          stall_cnt++;
        end
      end else begin
        after_eob = 0;
        gap_len++;
      end
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, ".cyc"},  bus.wb_cyc_o, 0);
    chk({pfx, ".stb"},  bus.wb_stb_o, 0);
    chk({pfx, ".we"},   bus.wb_we_o, 0);
    chk({pfx, ".cti"},  bus.wb_cti_o, 0);
    chk({pfx, ".bte"},  bus.wb_bte_o, 0);
    chk({pfx, ".sel"},  bus.wb_sel_o, 0);
    chk({pfx, ".adr"},  bus.wb_adr_o, 0);
    chk({pfx, ".dat"},  bus.wb_dat_o, 0);
    chk({pfx, ".busy"}, busy, 0);
    chk({pfx, ".done"}, done, 0);
    chk({pfx, ".pass"}, pass, 0);
    chk({pfx, ".err"},  err_count, 0);
    chk({pfx, ".fail"}, fail_addr, 0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [15:0] num;
    bit          corrupt;
    logic [31:0] caddr;
    bit          stall;
    logic [31:0] saddr;
    bit          busy_start;
    bit          seq;
    int          exp_wr;
    int          exp_rd;
    int          exp_stall;
    bit          exp_pass;
    logic [15:0] exp_err;
    logic [31:0] exp_fail;
  } vec_t;

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
    @(posedge wb_clk); #1;
    base_addr = b; num_words = n; start = 1'b1;
    @(posedge wb_clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int t, nwr, nrd, seq_bad, j;
    logic [31:0] eadr;
    logic [2:0]  ecti;
    corrupt_en = v.corrupt; corrupt_addr = v.caddr;
    stall_en = v.stall; stall_addr = v.saddr;
    pulse_start(v.base, v.num);
    if (v.busy_start) begin
      repeat (4) @(posedge wb_clk);
      #1; base_addr = 32'h200; num_words = 16'd0; start = 1'b1;
      @(posedge wb_clk); #1; start = 1'b0;
    end
    t = 0;
    while (done !== 1'b1 && t < 3000) begin
      @(negedge wb_clk); t++;
    end
    chk($sformatf("v%0d.done_seen", id), done, 1);
    @(negedge wb_clk); #1;
    chk($sformatf("v%0d.done_width", id), done, 0);
    chk($sformatf("v%0d.busy", id), busy, 0);
    chk($sformatf("v%0d.pass", id), pass, v.exp_pass);
    chk($sformatf("v%0d.err_count", id), err_count, v.exp_err);
    chk($sformatf("v%0d.fail_addr", id), fail_addr, v.exp_fail);
    chk($sformatf("v%0d.done_cnt", id), done_cnt, 1);
    chk($sformatf("v%0d.stall_cycles", id), stall_cnt, v.exp_stall);
    chk($sformatf("v%0d.proto", id), proto_bad, 0);
    nwr = 0; nrd = 0;
    for (int k = 0; k < nbeats && k < 64; k++) begin
      if (b_we[k]) nwr++; else nrd++;
    end
    chk($sformatf("v%0d.wr_beats", id), nwr, v.exp_wr);
    chk($sformatf("v%0d.rd_beats", id), nrd, v.exp_rd);
    if (v.seq) begin
      seq_bad = 0;
      for (int k = 0; k < nbeats && k < 64; k++) begin
        j = (k < int'(v.num)) ? k : k - int'(v.num);
        eadr = v.base + 32'(4 * j);
        ecti = ((j % BL) == BL - 1 || j == int'(v.num) - 1) ? 3'b111 : 3'b010;
        if (b_adr[k] !== eadr || b_cti[k] !== ecti || b_we[k] !== (k < int'(v.num)) ||
            (b_we[k] && b_dat[k] !== (eadr ^ SEED))) begin
          if (seq_bad == 0)
            $display("beat %0d: adr=%h cti=%b we=%b dat=%h (want adr=%h cti=%b)",
                     k, b_adr[k], b_cti[k], b_we[k], b_dat[k], eadr, ecti);
          seq_bad++;
        end
      end
      chk($sformatf("v%0d.beat_seq", id), seq_bad, 0);
    end
    corrupt_en = 1'b0; stall_en = 1'b0;
  endtask

  vec_t vecs [0:5];

  initial begin
    int t, dn;
    vecs[0] = '{32'h100, 16'd8, 0, 32'h0, 0, 32'h0, 1, 1, 8, 8, 0, 1, 16'd0, 32'h0};
    vecs[1] = '{32'h100, 16'd6, 0, 32'h0, 0, 32'h0, 0, 1, 6, 6, 0, 1, 16'd0, 32'h0};
    vecs[2] = '{32'h100, 16'd8, 1, 32'h108, 0, 32'h0, 0, 1, 8, 8, 0, 0, 16'd1, 32'h108};
    vecs[3] = '{32'h100, 16'd8, 0, 32'h0, 1, 32'h104, 0, 0, 1, 0, 255, 0, 16'd1, 32'h104};
    vecs[4] = '{32'hFFFF_FFF8, 16'd5, 0, 32'h0, 0, 32'h0, 0, 1, 5, 5, 0, 1, 16'd0, 32'h0};
    vecs[5] = '{32'h100, 16'd1, 0, 32'h0, 0, 32'h0, 0, 1, 1, 1, 0, 1, 16'd0, 32'h0};

    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    chk_outputs_zero("reset");
    wb_rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Zero-length test completes without touching the bus
    pulse_start(32'h300, 16'd0);
    t = 0;
    while (done !== 1'b1 && t < 10) begin
      @(negedge wb_clk); t++;
    end
    #1;
    chk("zero.done_seen", done, 1);
    chk("zero.latency_le2", (t <= 2), 1);
    chk("zero.no_cyc", had_burst, 0);
    chk("zero.pass", pass, 1);
    chk("zero.err_count", err_count, 0);
    chk("zero.fail_addr", fail_addr, 0);

    // Reset during the third write beat abandons the test silently
    pulse_start(32'h100, 16'd8);
    t = 0;
    while (nbeats < 3 && t < 50) begin
      @(negedge wb_clk); #1; t++;
    end
    chk("rst.reached_beat3", nbeats, 3);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    chk_outputs_zero("midrst");
    @(negedge wb_clk);
    wb_rst = 1'b0;
    dn = 0;
    repeat (30) begin
      @(negedge wb_clk);
      if (done === 1'b1) dn++;
    end
    chk("rst.no_done", dn, 0);
    chk("rst.idle_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
